// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared RV32I pipeline types: widths, ALU opcodes, ID/EX record.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SLT    = 4'd7,
        ALU_SLTU   = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_PASS_B = 4'd15
    } alu_op_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1_data;
        logic [XLEN-1:0]     rs2_data;
        logic [XLEN-1:0]     imm;
        logic [RADDR_W-1:0]  rs1;
        logic [RADDR_W-1:0]  rs2;
        logic [RADDR_W-1:0]  rd;
        alu_op_e             alu_ctrl;
        logic                sel_a;
        logic                sel_b;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
    } id_ex_t;

endpackage
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module   : forwarding_unit
// Brief    : Combinational rs1/rs2 bypass select; EX/MEM beats MEM/WB, x0 never bypassed.
// Revision : 1.0 - initial release
// ============================================================================
module forwarding_unit
    import cpu_pkg::*;
(
    input  logic [RADDR_W-1:0] i_rs1,
    input  logic [RADDR_W-1:0] i_rs2,
    input  logic [XLEN-1:0]    i_rs1_data,
    input  logic [XLEN-1:0]    i_rs2_data,
    input  logic [RADDR_W-1:0] i_exmem_rd,
    input  logic               i_exmem_reg_write,
    input  logic [XLEN-1:0]    i_exmem_alu_data,
    input  logic [RADDR_W-1:0] i_memwb_rd,
    input  logic               i_memwb_reg_write,
    input  logic [XLEN-1:0]    i_memwb_wb_data,
    output logic [XLEN-1:0]    o_rs1_data,
    output logic [XLEN-1:0]    o_rs2_data
);

    function automatic logic [XLEN-1:0] f_select(
        input logic [RADDR_W-1:0] rs,
        input logic [XLEN-1:0]    rf_data
    );
        if (rs == '0)
            f_select = rf_data;
        else if (i_exmem_reg_write && (i_exmem_rd == rs))
            f_select = i_exmem_alu_data;
        else if (i_memwb_reg_write && (i_memwb_rd == rs))
            f_select = i_memwb_wb_data;
        else
            f_select = rf_data;
    endfunction

    assign o_rs1_data = f_select(i_rs1, i_rs1_data);
    assign o_rs2_data = f_select(i_rs2, i_rs2_data);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Brief    : ID/EX pipeline register with operand select, forwarding and hazard
//            detection. Define ID_EX_FORWARDING_EN for bypassing; otherwise RAW
//            hazards are resolved by bubbling until the writer retires.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_id_valid,
    input  logic [XLEN-1:0]    i_id_pc,
    input  logic [XLEN-1:0]    i_id_rs1_data,
    input  logic [XLEN-1:0]    i_id_rs2_data,
    input  logic [XLEN-1:0]    i_id_imm,
    input  logic [RADDR_W-1:0] i_id_rs1,
    input  logic [RADDR_W-1:0] i_id_rs2,
    input  logic [RADDR_W-1:0] i_id_rd,
    input  logic [3:0]         i_id_alu_ctrl,
    input  logic               i_id_sel_a,
    input  logic               i_id_sel_b,
    input  logic               i_id_reg_write,
    input  logic               i_id_mem_read,
    input  logic               i_id_mem_write,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [RADDR_W-1:0] i_exmem_rd,
    input  logic               i_exmem_reg_write,
    input  logic [XLEN-1:0]    i_exmem_alu_data,
    input  logic [RADDR_W-1:0] i_memwb_rd,
    input  logic               i_memwb_reg_write,
    input  logic [XLEN-1:0]    i_memwb_wb_data,
    output logic [XLEN-1:0]    o_operand_a,
    output logic [XLEN-1:0]    o_operand_b,
    output logic [3:0]         o_alu_controller,
    output logic               o_ex_valid,
    output logic [XLEN-1:0]    o_ex_pc,
    output logic [RADDR_W-1:0] o_ex_rd,
    output logic               o_ex_reg_write,
    output logic               o_ex_mem_read,
    output logic               o_ex_mem_write,
    output logic [XLEN-1:0]    o_ex_store_data,
    output logic               o_hazard_stall
);

    id_ex_t          r_ex;
    id_ex_t          w_load;
    logic [XLEN-1:0] w_rs1_fwd;
    logic [XLEN-1:0] w_rs2_fwd;
    logic            w_hazard;

    always_comb begin
        w_load           = '0;
        w_load.valid     = i_id_valid;
        w_load.pc        = i_id_pc;
        w_load.rs1_data  = i_id_rs1_data;
        w_load.rs2_data  = i_id_rs2_data;
        w_load.imm       = i_id_imm;
        w_load.rs1       = i_id_rs1;
        w_load.rs2       = i_id_rs2;
        w_load.rd        = i_id_rd;
        w_load.alu_ctrl  = alu_op_e'(i_id_alu_ctrl);
        w_load.sel_a     = i_id_sel_a;
        w_load.sel_b     = i_id_sel_b;
        w_load.reg_write = i_id_reg_write & i_id_valid;
        w_load.mem_read  = i_id_mem_read  & i_id_valid;
        w_load.mem_write = i_id_mem_write & i_id_valid;
    end

    // Stall outranks the hazard bubble so a held instruction is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ex <= '0;
        else if (i_flush)
            r_ex <= '0;
        else if (!i_stall) begin
            if (w_hazard)
                r_ex <= '0;
            else
                r_ex <= w_load;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    forwarding_unit u_fwd (
        .i_rs1             (r_ex.rs1),
        .i_rs2             (r_ex.rs2),
        .i_rs1_data        (r_ex.rs1_data),
        .i_rs2_data        (r_ex.rs2_data),
        .i_exmem_rd        (i_exmem_rd),
        .i_exmem_reg_write (i_exmem_reg_write),
        .i_exmem_alu_data  (i_exmem_alu_data),
        .i_memwb_rd        (i_memwb_rd),
        .i_memwb_reg_write (i_memwb_reg_write),
        .i_memwb_wb_data   (i_memwb_wb_data),
        .o_rs1_data        (w_rs1_fwd),
        .o_rs2_data        (w_rs2_fwd)
    );

    assign w_hazard = i_id_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) &&
                      ((r_ex.rd == i_id_rs1) || (r_ex.rd == i_id_rs2));
`else
    // Any in-flight writer of a source register blocks decode until it retires.
    function automatic logic f_busy(input logic [RADDR_W-1:0] rs);
        f_busy = (rs != '0) &&
                 ((r_ex.valid && r_ex.reg_write && (r_ex.rd == rs)) ||
                  (i_exmem_reg_write && (i_exmem_rd == rs)) ||
                  (i_memwb_reg_write && (i_memwb_rd == rs)));
    endfunction

    assign w_hazard  = i_id_valid && (f_busy(i_id_rs1) || f_busy(i_id_rs2));
    assign w_rs1_fwd = r_ex.rs1_data;
    assign w_rs2_fwd = r_ex.rs2_data;

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{r_ex.rs1, r_ex.rs2, i_exmem_alu_data, i_memwb_wb_data};
`endif

    assign o_operand_a      = r_ex.sel_a ? r_ex.pc  : w_rs1_fwd;
    assign o_operand_b      = r_ex.sel_b ? r_ex.imm : w_rs2_fwd;
    assign o_alu_controller = r_ex.alu_ctrl;
    assign o_ex_valid       = r_ex.valid;
    assign o_ex_pc          = r_ex.pc;
    assign o_ex_rd          = r_ex.rd;
    assign o_ex_reg_write   = r_ex.valid & r_ex.reg_write;
    assign o_ex_mem_read    = r_ex.valid & r_ex.mem_read;
    assign o_ex_mem_write   = r_ex.valid & r_ex.mem_write;
    assign o_ex_store_data  = w_rs2_fwd;
    assign o_hazard_stall   = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed vector table plus hand sequences for id_ex_stage
//            (expectations follow ID_EX_FORWARDING_EN when defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid, id_sel_a, id_sel_b, id_rw, id_mr, id_mw, stall, flush;
    logic [31:0] id_pc, id_d1, id_d2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_rw, memwb_rw;
    logic [31:0] exmem_data, memwb_data;
    logic [31:0] opa, opb, ex_pc, st_data;
    logic [3:0]  alu_out;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_rw, ex_mr, ex_mw, hz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .i_id_valid        (id_valid),
        .i_id_pc           (id_pc),
        .i_id_rs1_data     (id_d1),
        .i_id_rs2_data     (id_d2),
        .i_id_imm          (id_imm),
        .i_id_rs1          (id_rs1),
        .i_id_rs2          (id_rs2),
        .i_id_rd           (id_rd),
        .i_id_alu_ctrl     (id_alu),
        .i_id_sel_a        (id_sel_a),
        .i_id_sel_b        (id_sel_b),
        .i_id_reg_write    (id_rw),
        .i_id_mem_read     (id_mr),
        .i_id_mem_write    (id_mw),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_reg_write (exmem_rw),
        .i_exmem_alu_data  (exmem_data),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_reg_write (memwb_rw),
        .i_memwb_wb_data   (memwb_data),
        .o_operand_a       (opa),
        .o_operand_b       (opb),
        .o_alu_controller  (alu_out),
        .o_ex_valid        (ex_valid),
        .o_ex_pc           (ex_pc),
        .o_ex_rd           (ex_rd),
        .o_ex_reg_write    (ex_rw),
        .o_ex_mem_read     (ex_mr),
        .o_ex_mem_write    (ex_mw),
        .o_ex_store_data   (st_data),
        .o_hazard_stall    (hz)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        sa, sb, rw, mr, mw, stl, fl;
        logic        ev;
        logic [31:0] ea, eb;
        logic [3:0]  ealu;
        logic [4:0]  erd;
        logic        erw, emr, emw;
        logic [31:0] est;
        logic        ehz;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] alu,
                          input logic sa, input logic sb, input logic rw, input logic mr,
                          input logic mw);
        id_valid = v;   id_pc = pc;   id_d1 = d1;   id_d2 = d2;   id_imm = imm;
        id_rs1 = rs1;   id_rs2 = rs2; id_rd = rd;   id_alu = alu;
        id_sel_a = sa;  id_sel_b = sb; id_rw = rw;  id_mr = mr;   id_mw = mw;
    endtask

    task automatic clr_wb();
        exmem_rd = '0; exmem_rw = 1'b0; exmem_data = '0;
        memwb_rd = '0; memwb_rw = 1'b0; memwb_data = '0;
    endtask

    initial begin
        //            v  pc        d1        d2        imm          rs1 rs2 rd alu sa sb rw mr mw st fl | ev ea        eb           alu rd rw mr mw st        hz
        tv[0] = '{1, 32'h100, 32'h5,    32'h7,    32'h0,        1,  2,  3, 0,  0, 0, 1, 0, 0, 0, 0,  1, 32'h5,    32'h7,       0,  3, 1, 0, 0, 32'h7,    0};
        tv[1] = '{1, 32'h104, 32'h0,    32'h55,   32'hFFFFFFFF, 0,  0,  7, 0,  0, 1, 1, 0, 0, 0, 0,  1, 32'h0,    32'hFFFFFFFF,0,  7, 1, 0, 0, 32'h55,   0};
        tv[2] = '{1, 32'h200, 32'h9,    32'h9,    32'h1000,     0,  0,  4, 0,  1, 1, 1, 0, 0, 0, 0,  1, 32'h200,  32'h1000,    0,  4, 1, 0, 0, 32'h9,    0};
        tv[3] = '{1, 32'h204, 32'h300,  32'hCAFE, 32'h8,        2,  8,  0, 0,  0, 1, 0, 0, 1, 0, 0,  1, 32'h300,  32'h8,       0,  0, 0, 0, 1, 32'hCAFE, 0};
        tv[4] = '{0, 32'h208, 32'h1234, 32'h5678, 32'h0,        20, 21, 9, 0,  0, 0, 1, 1, 1, 0, 0,  0, 32'h1234, 32'h5678,    0,  9, 0, 0, 0, 32'h5678, 0};
        tv[5] = '{1, 32'h20C, 32'h1,    32'h2,    32'h0,        3,  4,  5, 1,  0, 0, 1, 0, 0, 0, 1,  0, 32'h0,    32'h0,       0,  0, 0, 0, 0, 32'h0,    0};
        tv[6] = '{1, 32'h210, 32'hF0F0, 32'h0FF0, 32'h0,        10, 11, 12,4,  0, 0, 1, 0, 0, 0, 0,  1, 32'hF0F0, 32'h0FF0,    4,  12,1, 0, 0, 32'h0FF0, 0};
        tv[7] = '{1, 32'h214, 32'h1,    32'h2,    32'h0,        14, 15, 13,3,  0, 0, 1, 0, 0, 1, 0,  1, 32'hF0F0, 32'h0FF0,    4,  12,1, 0, 0, 32'h0FF0, 0};
        tv[8] = '{1, 32'h218, 32'h1,    32'h2,    32'h0,        14, 15, 13,3,  0, 0, 1, 0, 0, 1, 1,  0, 32'h0,    32'h0,       0,  0, 0, 0, 0, 32'h0,    0};
        tv[9] = '{1, 32'h21C, 32'h1000, 32'h0,    32'h4,        1,  0,  5, 0,  0, 1, 1, 1, 0, 0, 0,  1, 32'h1000, 32'h4,       0,  5, 1, 1, 0, 32'h0,    0};

        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stall = 1'b0; flush = 1'b0;
        clr_wb();

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_alu",   {28'd0, alu_out},  32'd0);
        chk("rst_opa",   opa,               32'd0);
        chk("rst_rw",    {31'd0, ex_rw},    32'd0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            set_id(tv[i].v, tv[i].pc, tv[i].d1, tv[i].d2, tv[i].imm, tv[i].rs1, tv[i].rs2,
                   tv[i].rd, tv[i].alu, tv[i].sa, tv[i].sb, tv[i].rw, tv[i].mr, tv[i].mw);
            stall = tv[i].stl;
            flush = tv[i].fl;
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, tv[i].ev});
            chk($sformatf("v%0d_opa", i),   opa,               tv[i].ea);
            chk($sformatf("v%0d_opb", i),   opb,               tv[i].eb);
            chk($sformatf("v%0d_alu", i),   {28'd0, alu_out},  {28'd0, tv[i].ealu});
            chk($sformatf("v%0d_rd", i),    {27'd0, ex_rd},    {27'd0, tv[i].erd});
            chk($sformatf("v%0d_rw", i),    {31'd0, ex_rw},    {31'd0, tv[i].erw});
            chk($sformatf("v%0d_mr", i),    {31'd0, ex_mr},    {31'd0, tv[i].emr});
            chk($sformatf("v%0d_mw", i),    {31'd0, ex_mw},    {31'd0, tv[i].emw});
            chk($sformatf("v%0d_store", i), st_data,           tv[i].est);
            chk($sformatf("v%0d_hz", i),    {31'd0, hz},       {31'd0, tv[i].ehz});
        end
        stall = 1'b0; flush = 1'b0;

        // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID
        set_id(1, 32'h220, 32'h0, 32'h3, 32'h0, 5, 1, 6, 0, 0, 0, 1, 0, 0);
        #1 chk("lu_hz", {31'd0, hz}, 32'd1);
        tick();
        exmem_rd = 5; exmem_rw = 1'b1; exmem_data = 32'h1004;
        #1 chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
`ifdef ID_EX_FORWARDING_EN
        chk("lu_hz_clear", {31'd0, hz}, 32'd0);
        tick();
        exmem_rw = 1'b0; memwb_rd = 5; memwb_rw = 1'b1; memwb_data = 32'hABCD;
        id_valid = 1'b0;
        #1;
`else
        chk("lu_hz_mem", {31'd0, hz}, 32'd1);
        tick();
        exmem_rw = 1'b0; memwb_rd = 5; memwb_rw = 1'b1; memwb_data = 32'hABCD;
        #1;
        chk("lu_bubble2", {31'd0, ex_valid}, 32'd0);
        chk("lu_hz_wb",   {31'd0, hz},       32'd1);
        tick();
        memwb_rw = 1'b0; id_d1 = 32'hABCD;
        #1;
        chk("lu_bubble3", {31'd0, ex_valid}, 32'd0);
        chk("lu_hz_done", {31'd0, hz},       32'd0);
        tick();
        id_valid = 1'b0;
        #1;
`endif
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_opa",   opa,               32'hABCD);
        chk("lu_opb",   opb,               32'h3);
        chk("lu_rd",    {27'd0, ex_rd},    32'd6);

        // Forwarding priority on ADD x3,x1,x2
        clr_wb();
        set_id(1, 32'h300, 32'h11, 32'h22, 32'h0, 1, 2, 3, 0, 0, 0, 1, 0, 0);
        tick();
        id_valid = 1'b0;
        exmem_rd = 1; exmem_rw = 1'b1; exmem_data = 32'h10;
        memwb_rd = 1; memwb_rw = 1'b1; memwb_data = 32'h20;
`ifdef ID_EX_FORWARDING_EN
        #1 chk("fw_exmem_prio", opa, 32'h10);
        exmem_rw = 1'b0;
        #1 chk("fw_memwb", opa, 32'h20);
        memwb_rd = 2; memwb_data = 32'h77;
        #1 chk("fw_rs2_memwb", opb, 32'h77);
        chk("fw_store", st_data, 32'h77);
        exmem_rd = 2; exmem_rw = 1'b1; exmem_data = 32'h88;
        #1 chk("fw_rs2_exmem", opb, 32'h88);
`else
        #1 chk("nofw_opa", opa, 32'h11);
        exmem_rw = 1'b0;
        #1 chk("nofw_opa2", opa, 32'h11);
        memwb_rd = 2; memwb_data = 32'h77;
        #1 chk("nofw_opb", opb, 32'h22);
        chk("nofw_store", st_data, 32'h22);
        exmem_rd = 2; exmem_rw = 1'b1; exmem_data = 32'h88;
        #1 chk("nofw_opb2", opb, 32'h22);
`endif
        chk("fw_rs1_untouched", opa, 32'h11);
        clr_wb();

        // x0 is never forwarded nor a hazard source
        set_id(1, 32'h400, 32'h0, 32'h0, 32'h0, 0, 0, 3, 0, 0, 0, 1, 0, 0);
        exmem_rd = 0; exmem_rw = 1'b1; exmem_data = 32'hDEAD;
        memwb_rd = 0; memwb_rw = 1'b1; memwb_data = 32'hBEEF;
        #1 chk("x0_hz", {31'd0, hz}, 32'd0);
        tick();
        id_valid = 1'b0;
        #1;
        chk("x0_valid", {31'd0, ex_valid}, 32'd1);
        chk("x0_opa",   opa,               32'd0);
        chk("x0_store", st_data,           32'd0);
        clr_wb();

        // ADDI x7,x0,-1 then RAW on x7
        set_id(1, 32'h500, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 7, 0, 0, 1, 1, 0, 0);
        tick();
        chk("addi_opb", opb,            32'hFFFFFFFF);
        chk("addi_rd",  {27'd0, ex_rd}, 32'd7);
        set_id(1, 32'h504, 32'h0, 32'h0, 32'h0, 7, 0, 8, 0, 0, 0, 1, 0, 0);
        #1;
`ifdef ID_EX_FORWARDING_EN
        chk("raw_hz", {31'd0, hz}, 32'd0);
        tick();
        exmem_rd = 7; exmem_rw = 1'b1; exmem_data = 32'hFFFFFFFF;
        id_valid = 1'b0;
        #1;
`else
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("raw_hz%0d", k), {31'd0, hz}, 32'd1);
            tick();
            if (k == 0) begin
                exmem_rd = 7; exmem_rw = 1'b1; exmem_data = 32'hFFFFFFFF;
            end else if (k == 1) begin
                exmem_rw = 1'b0; memwb_rd = 7; memwb_rw = 1'b1; memwb_data = 32'hFFFFFFFF;
            end else begin
                memwb_rw = 1'b0; id_d1 = 32'hFFFFFFFF;
            end
            #1 chk($sformatf("raw_bubble%0d", k), {31'd0, ex_valid}, 32'd0);
        end
        chk("raw_hz_clear", {31'd0, hz}, 32'd0);
        tick();
        id_valid = 1'b0;
        #1;
`endif
        chk("raw_valid", {31'd0, ex_valid}, 32'd1);
        chk("raw_opa",   opa,               32'hFFFFFFFF);
        chk("raw_rd",    {27'd0, ex_rd},    32'd8);
        clr_wb();

        // Stall for three cycles holds the EX slot
        set_id(1, 32'h600, 32'hA, 32'hB, 32'h0, 16, 17, 18, 4, 0, 0, 1, 0, 0);
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_id(1, 32'h700 + k, k, k + 1, 32'h0, 18, 1, 19, 3, 0, 0, 1, 0, 0);
            tick();
            chk($sformatf("stl%0d_valid", k), {31'd0, ex_valid}, 32'd1);
            chk($sformatf("stl%0d_opa", k),   opa,               32'hA);
            chk($sformatf("stl%0d_opb", k),   opb,               32'hB);
            chk($sformatf("stl%0d_pc", k),    ex_pc,             32'h600);
            chk($sformatf("stl%0d_rd", k),    {27'd0, ex_rd},    32'd18);
            chk($sformatf("stl%0d_alu", k),   {28'd0, alu_out},  32'd4);
        end
        stall = 1'b0;

        // Asynchronous reset mid-run
        set_id(1, 32'h800, 32'h5, 32'h6, 32'h0, 0, 0, 9, 1, 0, 0, 1, 1, 1);
        tick();
        chk("pre_rst_mr", {31'd0, ex_mr}, 32'd1);
        id_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_rw",    {31'd0, ex_rw},    32'd0);
        chk("arst_mr",    {31'd0, ex_mr},    32'd0);
        chk("arst_mw",    {31'd0, ex_mw},    32'd0);
        chk("arst_alu",   {28'd0, alu_out},  32'd0);
        chk("arst_opa",   opa,               32'd0);
        chk("arst_rd",    {27'd0, ex_rd},    32'd0);
        tick();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
